// File: rtl/work_ram_ctrl_pkg.sv
// work_ram_ctrl_pkg
// Shared definitions for the 68k work-RAM controller: FSM state encoding,
// the work-RAM base decode value and the mirror-decode value.
package work_ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } wram_state_e;

  // A[23:16] value of the un-mirrored 64 KiB work-RAM window (0x10xxxx).
  localparam logic [7:0] WRAM_BASE        = 8'h10;
  // A[23:20] value decoded when mirroring is enabled (0x1xxxxx).
  localparam logic [3:0] WRAM_MIRROR_MASK = 4'h1;

endpackage

// File: rtl/work_ram_ctrl_wait_counter.sv
// wram_wait_counter
// 4-bit down-counter that times the SRAM strobe window.
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset (count -> 0)
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement by one
//   o_zero     count is zero
module wram_wait_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/work_ram_ctrl.sv
// work_ram_ctrl
// Bridges 68k bus cycles to a pair of byte-wide asynchronous SRAMs
// (64 KiB work RAM) and generates nDTACK after a fixed wait.
// Optional feature: define WRAM_MIRROR_EN to decode 0x100000-0x1FFFFF
// (RAM mirrored every 0x10000); otherwise only 0x100000-0x10FFFF hits.
// Ports:
//   CLK_24M      clock, all logic on rising edge
//   RESET        synchronous active-high reset
//   M68K_ADDR    A[23:1]
//   nAS/nUDS/nLDS/RW  68k bus control (strobes active-low, RW 1 = read)
//   WRAM_ADDR    latched A[15:1]
//   nWRAM_CE/nWRAM_OE/nWRAM_WEU/nWRAM_WEL  SRAM strobes, active-low
//   nDTACK       data acknowledge, active-low
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a hit; only state that accepts a new access
// ACCESS   | strobes active, wait counter running
// ACK      | nDTACK low; read keeps CE/OE low until nAS rises
// RELEASE  | all outputs inactive for one cycle before IDLE
module work_ram_ctrl
  import work_ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic         CLK_24M,
  input  logic         RESET,
  input  logic [23:1]  M68K_ADDR,
  input  logic         nAS,
  input  logic         nUDS,
  input  logic         nLDS,
  input  logic         RW,
  output logic [14:0]  WRAM_ADDR,
  output logic         nWRAM_CE,
  output logic         nWRAM_OE,
  output logic         nWRAM_WEU,
  output logic         nWRAM_WEL,
  output logic         nDTACK
);

  localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  wram_state_e r_state;
  logic [14:0] r_addr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_weu_n;
  logic        r_wel_n;
  logic        r_dtack_n;

  logic        w_region;
  logic        w_hit;
  logic        w_load;
  logic        w_dec;
  logic        w_zero;

`ifdef WRAM_MIRROR_EN
  logic w_unused_mirror_bits;
  assign w_region             = (M68K_ADDR[23:20] == WRAM_MIRROR_MASK);
  assign w_unused_mirror_bits = ^M68K_ADDR[19:16];
`else
  assign w_region = (M68K_ADDR[23:16] == WRAM_BASE);
`endif

  assign w_hit  = w_region && !nAS && (!nUDS || !nLDS);
  assign w_load = (r_state == ST_IDLE) && w_hit;
  // Stop decrementing once zero so the counter rests at 0 between accesses.
  assign w_dec  = (r_state == ST_ACCESS) && !nAS && !w_zero;

  wram_wait_counter u_wait (
    .i_clk      (CLK_24M),
    .i_rst      (RESET),
    .i_load     (w_load),
    .i_load_val (LP_WAIT_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_addr    <= 15'd0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_weu_n   <= 1'b1;
      r_wel_n   <= 1'b1;
      r_dtack_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            // Bus qualifiers are captured into the strobe registers here;
            // later bus changes cannot alter them until the next IDLE.
            r_state <= ST_ACCESS;
            r_addr  <= M68K_ADDR[15:1];
            r_ce_n  <= 1'b0;
            r_oe_n  <= ~RW;
            r_weu_n <= RW | nUDS;
            r_wel_n <= RW | nLDS;
          end
        end
        ST_ACCESS: begin
          if (nAS) begin
            // Aborted cycle: release without ever acknowledging.
            r_state   <= ST_RELEASE;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_weu_n   <= 1'b1;
            r_wel_n   <= 1'b1;
            r_dtack_n <= 1'b1;
          end else if (w_zero) begin
            r_state   <= ST_ACK;
            r_weu_n   <= 1'b1;
            r_wel_n   <= 1'b1;
            r_dtack_n <= 1'b0;
          end
        end
        ST_ACK: begin
          if (nAS) begin
            r_state   <= ST_RELEASE;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_weu_n   <= 1'b1;
            r_wel_n   <= 1'b1;
            r_dtack_n <= 1'b1;
          end
        end
        ST_RELEASE: begin
          r_state   <= ST_IDLE;
          r_ce_n    <= 1'b1;
          r_oe_n    <= 1'b1;
          r_weu_n   <= 1'b1;
          r_wel_n   <= 1'b1;
          r_dtack_n <= 1'b1;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_ce_n    <= 1'b1;
          r_oe_n    <= 1'b1;
          r_weu_n   <= 1'b1;
          r_wel_n   <= 1'b1;
          r_dtack_n <= 1'b1;
        end
      endcase
    end
  end

  assign WRAM_ADDR = r_addr;
  assign nWRAM_CE  = r_ce_n;
  assign nWRAM_OE  = r_oe_n;
  assign nWRAM_WEU = r_weu_n;
  assign nWRAM_WEL = r_wel_n;
  assign nDTACK    = r_dtack_n;

endmodule

// File: tb/tb_work_ram_ctrl.sv
module tb_work_ram_ctrl;

`ifdef WRAM_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:1] addr = '0;
  logic        nas = 1'b1;
  logic        nuds = 1'b1;
  logic        nlds = 1'b1;
  logic        rw = 1'b1;

  logic [14:0] wa_v [3];
  logic        ce_v [3];
  logic        oe_v [3];
  logic        weu_v[3];
  logic        wel_v[3];
  logic        dt_v [3];

  int n_cmp = 0;
  int n_err = 0;

  always #21 clk = ~clk;

  work_ram_ctrl u_w3 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr), .nAS(nas), .nUDS(nuds),
    .nLDS(nlds), .RW(rw), .WRAM_ADDR(wa_v[0]), .nWRAM_CE(ce_v[0]),
    .nWRAM_OE(oe_v[0]), .nWRAM_WEU(weu_v[0]), .nWRAM_WEL(wel_v[0]),
    .nDTACK(dt_v[0]));

  work_ram_ctrl #(.WAIT_CYCLES(1)) u_w1 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr), .nAS(nas), .nUDS(nuds),
    .nLDS(nlds), .RW(rw), .WRAM_ADDR(wa_v[1]), .nWRAM_CE(ce_v[1]),
    .nWRAM_OE(oe_v[1]), .nWRAM_WEU(weu_v[1]), .nWRAM_WEL(wel_v[1]),
    .nDTACK(dt_v[1]));

  work_ram_ctrl #(.WAIT_CYCLES(15)) u_w15 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr), .nAS(nas), .nUDS(nuds),
    .nLDS(nlds), .RW(rw), .WRAM_ADDR(wa_v[2]), .nWRAM_CE(ce_v[2]),
    .nWRAM_OE(oe_v[2]), .nWRAM_WEU(weu_v[2]), .nWRAM_WEL(wel_v[2]),
    .nDTACK(dt_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [23:0] byte_addr, input logic r, input logic u, input logic l);
    addr = byte_addr[23:1];
    rw   = r;
    nuds = u;
    nlds = l;
    nas  = 1'b0;
  endtask

  task automatic idle_bus();
    nas  = 1'b1;
    nuds = 1'b1;
    nlds = 1'b1;
  endtask

  // Continuous checks on every instance: OE/WE exclusivity and nDTACK latency.
  localparam int WV[3] = '{3, 1, 15};
  int   lat [3] = '{0, 0, 0};
  int   acks[3] = '{0, 0, 0};
  logic pdt [3] = '{1'b1, 1'b1, 1'b1};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        chk("oe_we_overlap", {31'b0, (!oe_v[i] && (!weu_v[i] || !wel_v[i]))}, 32'd0);
        if (ce_v[i]) lat[i] = 0;
        else if (dt_v[i]) lat[i]++;
        else if (pdt[i]) begin
          chk("dtack_latency", 32'(lat[i]), 32'(WV[i]));
          acks[i]++;
        end
      end
      pdt[i] = dt_v[i];
    end
  end

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(); cyc();
    chk("rst_ce",    {31'b0, ce_v[0]},  32'd1);
    chk("rst_oe",    {31'b0, oe_v[0]},  32'd1);
    chk("rst_weu",   {31'b0, weu_v[0]}, 32'd1);
    chk("rst_wel",   {31'b0, wel_v[0]}, 32'd1);
    chk("rst_dtack", {31'b0, dt_v[0]},  32'd1);
    chk("rst_addr",  {17'b0, wa_v[0]},  32'd0);
    rst = 1'b0;
    cyc();

    // Word read at 0x100002
    bus(24'h100002, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("rd_addr",  {17'b0, wa_v[0]}, 32'h0001);
    chk("rd_ce",    {31'b0, ce_v[0]}, 32'd0);
    chk("rd_oe",    {31'b0, oe_v[0]}, 32'd0);
    chk("rd_we",    {30'b0, weu_v[0], wel_v[0]}, 32'd3);
    chk("rd_dt_c1", {31'b0, dt_v[0]}, 32'd1);
    cyc();
    chk("rd_dt_c2", {31'b0, dt_v[0]}, 32'd1);
    cyc();
    chk("rd_dt_c3", {31'b0, dt_v[0]}, 32'd1);
    cyc();
    chk("rd_dt_c4", {31'b0, dt_v[0]}, 32'd0);
    chk("rd_oe_c4", {31'b0, oe_v[0]}, 32'd0);
    cyc();
    chk("rd_ack_hold_dt", {31'b0, dt_v[0]}, 32'd0);
    chk("rd_ack_hold_ce", {31'b0, ce_v[0]}, 32'd0);
    idle_bus();
    cyc();
    chk("rd_rel_ce", {31'b0, ce_v[0]}, 32'd1);
    chk("rd_rel_oe", {31'b0, oe_v[0]}, 32'd1);
    chk("rd_rel_dt", {31'b0, dt_v[0]}, 32'd1);
    // New hit presented during RELEASE is only taken from IDLE
    bus(24'h100000, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("b2b_rel_ce", {31'b0, ce_v[0]}, 32'd1);
    cyc();
    chk("b2b_idle_ce", {31'b0, ce_v[0]}, 32'd0);
    idle_bus();
    cyc(); cyc();

    // Lower-byte write at 0x10FFFE, bus changes after latch are ignored
    bus(24'h10FFFE, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("wr_addr", {17'b0, wa_v[0]}, 32'h7FFF);
    chk("wr_wel1", {31'b0, wel_v[0]}, 32'd0);
    chk("wr_weu1", {31'b0, weu_v[0]}, 32'd1);
    chk("wr_oe1",  {31'b0, oe_v[0]}, 32'd1);
    addr = 23'h080010;
    rw   = 1'b1;
    nuds = 1'b0;
    cyc();
    chk("wr_wel2",      {31'b0, wel_v[0]}, 32'd0);
    chk("wr_weu2",      {31'b0, weu_v[0]}, 32'd1);
    chk("wr_oe2",       {31'b0, oe_v[0]}, 32'd1);
    chk("wr_addr_hold", {17'b0, wa_v[0]}, 32'h7FFF);
    cyc();
    chk("wr_wel3", {31'b0, wel_v[0]}, 32'd0);
    cyc();
    chk("wr_wel_ack", {31'b0, wel_v[0]}, 32'd1);
    chk("wr_dt_ack",  {31'b0, dt_v[0]}, 32'd0);
    chk("wr_oe_ack",  {31'b0, oe_v[0]}, 32'd1);
    idle_bus();
    cyc();
    chk("wr_rel_ce", {31'b0, ce_v[0]}, 32'd1);
    chk("wr_rel_dt", {31'b0, dt_v[0]}, 32'd1);
    cyc();

    // Access at 0x110000: only a hit when mirroring is built in
    bus(24'h110000, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("mir_ce", {31'b0, ce_v[0]}, MIR ? 32'd0 : 32'd1);
    chk("mir_oe", {31'b0, oe_v[0]}, MIR ? 32'd0 : 32'd1);
    if (MIR) chk("mir_addr", {17'b0, wa_v[0]}, 32'h0000);
    cyc(); cyc(); cyc();
    chk("mir_dt", {31'b0, dt_v[0]}, MIR ? 32'd0 : 32'd1);
    cyc();
    chk("mir_dt_hold", {31'b0, dt_v[0]}, MIR ? 32'd0 : 32'd1);
    idle_bus();
    cyc(); cyc();

    // Aborted read: nAS rises during ACCESS
    bus(24'h100000, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("abt_ce_c1", {31'b0, ce_v[0]}, 32'd0);
    cyc();
    idle_bus();
    cyc();
    chk("abt_ce", {31'b0, ce_v[0]}, 32'd1);
    chk("abt_oe", {31'b0, oe_v[0]}, 32'd1);
    chk("abt_we", {30'b0, weu_v[0], wel_v[0]}, 32'd3);
    chk("abt_dt", {31'b0, dt_v[0]}, 32'd1);
    cyc(); cyc();
    chk("abt_dt_later", {31'b0, dt_v[0]}, 32'd1);

    // Reset during ACK of a read, then a clean read at 0x100000
    bus(24'h100004, 1'b1, 1'b0, 1'b0);
    cyc(); cyc(); cyc(); cyc();
    chk("rack_dt", {31'b0, dt_v[0]}, 32'd0);
    chk("rack_addr", {17'b0, wa_v[0]}, 32'h0002);
    rst = 1'b1;
    cyc();
    chk("rack_rst_ce",   {31'b0, ce_v[0]}, 32'd1);
    chk("rack_rst_oe",   {31'b0, oe_v[0]}, 32'd1);
    chk("rack_rst_dt",   {31'b0, dt_v[0]}, 32'd1);
    chk("rack_rst_addr", {17'b0, wa_v[0]}, 32'h0000);
    rst = 1'b0;
    idle_bus();
    cyc();
    chk("rack_idle_ce", {31'b0, ce_v[0]}, 32'd1);
    bus(24'h100000, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("post_rst_ce", {31'b0, ce_v[0]}, 32'd0);
    chk("post_rst_oe", {31'b0, oe_v[0]}, 32'd0);
    cyc(); cyc();
    chk("post_rst_dt3", {31'b0, dt_v[0]}, 32'd1);
    cyc();
    chk("post_rst_dt4", {31'b0, dt_v[0]}, 32'd0);
    idle_bus();
    cyc();
    chk("post_rst_rel", {31'b0, dt_v[0]}, 32'd1);
    cyc();

    // Random bus traffic, checked by the monitor on all three instances
    begin
      int ncyc;
      ncyc = 0;
      while (ncyc < 1000) begin
        logic [23:0] ba;
        int kind, hold, gap;
        kind = $urandom_range(0, 3);
        ba = 24'($urandom);
        if (kind <= 1)      ba[23:16] = 8'h10;
        else if (kind == 2) ba[23:16] = 8'h11;
        ba[0] = 1'b0;
        bus(ba, 1'($urandom), 1'($urandom), 1'($urandom));
        hold = $urandom_range(1, 24);
        for (int k = 0; k < hold; k++) begin
          if ($urandom_range(0, 7) == 0) rw = ~rw;
          cyc();
        end
        idle_bus();
        gap = $urandom_range(1, 3);
        for (int k = 0; k < gap; k++) cyc();
        ncyc += hold + gap;
      end
      cyc(); cyc();
      chk("w1_acks_seen",  {31'b0, (acks[1] > 0)}, 32'd1);
      chk("w15_acks_seen", {31'b0, (acks[2] > 0)}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
